// File: rtl/cdb_broadcast.sv
// cdb_broadcast: completion-tag collector and two-stage wakeup/CDB broadcaster.
// Completed FU tags are selected oldest-first, up to N_WAY per cycle.
// The overflow queue is served before this cycle's inputs.
// Each selected tag appears on ex_rs_dest_idx for one cycle as an early wakeup.
// It then appears on cdb_rs_reg_idx for one cycle as the CDB broadcast.
// Backpressure is a registered, all-or-nothing stall. It guarantees that a
// full cycle of FU completions always fits in the queue.
module cdb_broadcast #(
  parameter int N_WAY       = 3,
  parameter int CDB_BITS    = 6,
  parameter int N_FU        = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_FU-1:0]                    fu_done_valid,
  input  logic [N_FU-1:0][CDB_BITS-1:0]      fu_done_tag,
  output logic [N_FU-1:0]                    fu_stall,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     ex_rs_dest_idx,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     cdb_rs_reg_idx,
  output logic [N_WAY-1:0]                   cdb_valid,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);

  typedef logic [CDB_BITS-1:0] tag_t;

  // Circular overflow queue: storage, head pointer, occupancy.
  tag_t                          r_q [QUEUE_DEPTH];
  tag_t                          w_q_next [QUEUE_DEPTH];
  logic [PTR_W-1:0]              r_head;
  logic [PTR_W-1:0]              w_head_next;
  logic [CNT_W-1:0]              r_count;
  logic [CNT_W-1:0]              w_count_next;

  // Broadcast pipeline and backpressure.
  logic [N_WAY-1:0][CDB_BITS-1:0] r_ex;
  logic [N_WAY-1:0][CDB_BITS-1:0] r_cdb;
  logic [N_WAY-1:0]               r_cdb_valid;
  logic [N_FU-1:0]                r_fu_stall;
  logic [N_WAY-1:0][CDB_BITS-1:0] w_sel;
  logic                           w_stall_next;

  // Queue indices never reach 2*QUEUE_DEPTH, so one conditional subtract
  // is enough to wrap them.
  function automatic int f_wrap(input int idx);
    return (idx >= QUEUE_DEPTH) ? idx - QUEUE_DEPTH : idx;
  endfunction

  // Select lanes: queue head first, then this cycle's accepted inputs in FU
  // order. Accepted inputs that do not fit in a lane are appended at the tail.
  always_comb begin
    int n_pop;
    int lane;
    int n_push;
    int cnt_post;
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    w_sel        = '0;
    w_q_next     = r_q;
    n_pop        = (int'(r_count) > N_WAY) ? N_WAY : int'(r_count);
    lane         = n_pop;
    n_push       = 0;

    for (int j = 0; j < N_WAY; j++) begin
      if (j < n_pop) begin
        for (int d = 0; d < QUEUE_DEPTH; d++) begin
          if (d == f_wrap(int'(r_head) + j)) begin
            w_sel[j] = r_q[d];
          end
        end
      end
    end

    for (int i = 0; i < N_FU; i++) begin
      // A stalled FU is not consumed. The null tag is consumed but dropped.
      if (fu_done_valid[i] && !r_fu_stall[i] && (fu_done_tag[i] != '0)) begin
        if (lane < N_WAY) begin
          for (int j = 0; j < N_WAY; j++) begin
            if (j == lane) begin
              w_sel[j] = fu_done_tag[i];
            end
          end
          lane++;
        end else begin
          for (int d = 0; d < QUEUE_DEPTH; d++) begin
            if (d == f_wrap(int'(r_head) + int'(r_count) + n_push)) begin
              w_q_next[d] = fu_done_tag[i];
            end
          end
          n_push++;
        end
      end
    end

    cnt_post     = int'(r_count) - n_pop + n_push;
    w_head_next  = PTR_W'(f_wrap(int'(r_head) + n_pop));
    w_count_next = CNT_W'(cnt_post);
    // Stall when the free space left after this edge cannot hold
    // a full set of FU completions.
    w_stall_next = (QUEUE_DEPTH - cnt_post) < N_FU;
  end

  // Queue storage: valid entries are tracked only by head and count.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is not reset. Occupancy alone decides which
    // entries are live, so clearing the data would only add reset fan-out.
    r_q <= w_q_next;
  end

  // Pipeline stages, queue pointers and registered stall, with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments. The cdb stage then
    // samples the ex stage as it was before this edge, not the new selection.
    if (reset) begin
      r_ex        <= '0;
      r_cdb       <= '0;
      r_cdb_valid <= '0;
      r_head      <= '0;
      r_count     <= '0;
      r_fu_stall  <= '0;
    end else begin
      r_ex    <= w_sel;
      r_cdb   <= r_ex;
      for (int j = 0; j < N_WAY; j++) begin
        r_cdb_valid[j] <= (r_ex[j] != '0);
      end
      r_head     <= w_head_next;
      r_count    <= w_count_next;
      r_fu_stall <= {N_FU{w_stall_next}};
    end
  end

  assign ex_rs_dest_idx = r_ex;
  assign cdb_rs_reg_idx = r_cdb;
  assign cdb_valid      = r_cdb_valid;
  assign queue_count    = r_count;
  assign fu_stall       = r_fu_stall;

endmodule

// File: tb/tb_cdb_broadcast.sv
// Self-checking bench for cdb_broadcast.
// The reference model is a single FIFO of pending tags. Each edge it appends
// this cycle's accepted non-null inputs and then pops up to N_WAY into the
// ex stage.
module tb_cdb_broadcast;

  localparam int N_WAY       = 3;
  localparam int CDB_BITS    = 6;
  localparam int N_FU        = 4;
  localparam int QUEUE_DEPTH = 8;

  logic                           clock = 1'b0;
  logic                           reset = 1'b1;
  logic [N_FU-1:0]                fu_done_valid;
  logic [N_FU-1:0][CDB_BITS-1:0]  fu_done_tag;
  logic [N_FU-1:0]                fu_stall;
  logic [N_WAY-1:0][CDB_BITS-1:0] ex_rs_dest_idx;
  logic [N_WAY-1:0][CDB_BITS-1:0] cdb_rs_reg_idx;
  logic [N_WAY-1:0]               cdb_valid;
  logic [3:0]                     queue_count;

  cdb_broadcast #(
    .N_WAY(N_WAY), .CDB_BITS(CDB_BITS), .N_FU(N_FU), .QUEUE_DEPTH(QUEUE_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fu_done_valid  (fu_done_valid),
    .fu_done_tag    (fu_done_tag),
    .fu_stall       (fu_stall),
    .ex_rs_dest_idx (ex_rs_dest_idx),
    .cdb_rs_reg_idx (cdb_rs_reg_idx),
    .cdb_valid      (cdb_valid),
    .queue_count    (queue_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_q[$];
  int m_ex[N_WAY];
  int m_cdb[N_WAY];
  bit m_stall;
  int next_tag_v = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model one clock edge using the inputs and the model stall seen before the edge.
  task automatic model_edge();
    if (reset) begin
      m_q.delete();
      for (int j = 0; j < N_WAY; j++) begin
        m_ex[j]  = 0;
        m_cdb[j] = 0;
      end
      m_stall = 1'b0;
    end else begin
      for (int j = 0; j < N_WAY; j++) m_cdb[j] = m_ex[j];
      if (!m_stall) begin
        for (int i = 0; i < N_FU; i++) begin
          if (fu_done_valid[i] && fu_done_tag[i] != 0) m_q.push_back(int'(fu_done_tag[i]));
        end
      end
      for (int j = 0; j < N_WAY; j++) m_ex[j] = (m_q.size() > 0) ? m_q.pop_front() : 0;
      m_stall = (QUEUE_DEPTH - m_q.size()) < N_FU;
    end
  endtask

  task automatic compare();
    logic [N_WAY-1:0] ev;
    ev = '0;
    for (int j = 0; j < N_WAY; j++) begin
      check($sformatf("ex_lane%0d", j), 32'(ex_rs_dest_idx[j]), m_ex[j]);
      check($sformatf("cdb_lane%0d", j), 32'(cdb_rs_reg_idx[j]), m_cdb[j]);
      ev[j] = (m_cdb[j] != 0);
    end
    check("cdb_valid", 32'(cdb_valid), 32'(ev));
    check("queue_count", 32'(queue_count), m_q.size());
    check("fu_stall", 32'(fu_stall), m_stall ? 32'hF : 32'h0);
  endtask

  // One edge: advance the model, then sample the DUT 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic [N_FU-1:0] v, input int t0, input int t1, input int t2, input int t3);
    fu_done_valid  = v;
    fu_done_tag[0] = CDB_BITS'(t0);
    fu_done_tag[1] = CDB_BITS'(t1);
    fu_done_tag[2] = CDB_BITS'(t2);
    fu_done_tag[3] = CDB_BITS'(t3);
  endtask

  task automatic idle();
    fu_done_valid = '0;
  endtask

  function automatic int next_tag();
    int t;
    t = next_tag_v;
    next_tag_v = (next_tag_v == 63) ? 1 : next_tag_v + 1;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fu_done_valid = '0;
    fu_done_tag   = '0;

    // 1: reset held for two edges, then one idle edge.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t1_count", 32'(queue_count), 0);
    check("t1_stall", 32'(fu_stall), 0);

    // 2: single tag through both stages.
    drive(4'b0001, 33, 0, 0, 0);
    tick();
    check("t2_ex", 32'(ex_rs_dest_idx), 32'({6'd0, 6'd0, 6'd33}));
    idle();
    tick();
    check("t2_cdb", 32'(cdb_rs_reg_idx), 32'd33);
    check("t2_valid", 32'(cdb_valid), 32'b001);
    tick();
    check("t2_ex_clear", 32'(ex_rs_dest_idx), 0);
    check("t2_cdb_clear", 32'(cdb_rs_reg_idx), 0);

    // 3: four tags, one overflows into the queue.
    drive(4'b1111, 33, 34, 35, 36);
    tick();
    check("t3_ex", 32'(ex_rs_dest_idx), 32'({6'd35, 6'd34, 6'd33}));
    check("t3_count1", 32'(queue_count), 1);
    idle();
    tick();
    check("t3_ex_drain", 32'(ex_rs_dest_idx), 32'({6'd0, 6'd0, 6'd36}));
    check("t3_count0", 32'(queue_count), 0);
    tick();
    check("t3_cdb", 32'(cdb_rs_reg_idx), 32'({6'd0, 6'd0, 6'd36}));

    // 4: queued 40 goes first, then 41; the null tag is dropped.
    drive(4'b1111, 37, 38, 39, 40);
    tick();
    drive(4'b0110, 0, 41, 0, 0);
    tick();
    check("t4_ex", 32'(ex_rs_dest_idx), 32'({6'd0, 6'd41, 6'd40}));
    check("t4_count", 32'(queue_count), 0);
    idle();
    tick();
    check("t4_valid", 32'(cdb_valid), 32'b011);
    tick();
    tick();

    // 5: saturation. All FUs complete every cycle; stalled FUs hold their inputs.
    for (int c = 0; c < 20; c++) begin
      if (!m_stall) drive(4'b1111, next_tag(), next_tag(), next_tag(), next_tag());
      tick();
      if (c == 3) check("t5_count4_nostall", 32'(fu_stall), 0);
      if (c == 4) begin
        check("t5_count5", 32'(queue_count), 5);
        check("t5_stall_on", 32'(fu_stall), 32'hF);
      end
      if (c == 5) begin
        check("t5_drain", 32'(queue_count), 2);
        check("t5_stall_off", 32'(fu_stall), 0);
      end
    end
    idle();
    for (int c = 0; c < 4; c++) tick();
    check("t5_empty", 32'(queue_count), 0);

    // 6: reset with queue, ex and cdb all occupied.
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, next_tag(), next_tag(), next_tag(), next_tag());
      tick();
    end
    check("t6_count3", 32'(queue_count), 3);
    reset = 1'b1;
    tick();
    check("t6_ex", 32'(ex_rs_dest_idx), 0);
    check("t6_cdb", 32'(cdb_rs_reg_idx), 0);
    check("t6_count", 32'(queue_count), 0);
    check("t6_stall", 32'(fu_stall), 0);
    reset = 1'b0;
    idle();
    for (int c = 0; c < 3; c++) tick();
    check("t6_cdb_quiet", 32'(cdb_rs_reg_idx), 0);

    // Randomized traffic with occasional reset mid-operation.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!m_stall) begin
        for (int i = 0; i < N_FU; i++) begin
          fu_done_valid[i] = ($urandom_range(0, 2) != 0);
          fu_done_tag[i]   = ($urandom_range(0, 7) == 0) ? '0 : CDB_BITS'($urandom_range(1, 63));
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Producer end of the wakeup/completion interface that the reservation station consumes.
- Collects completed destination tags from the functional units and buffers any overflow in an oldest-first queue.
- Per cycle, selects up to N_WAY tags. Each selected tag goes out first as an early wakeup on ex_rs_dest_idx, then one cycle later as the CDB broadcast on cdb_rs_reg_idx.
- Sits between the execute stage and the reservation station, map table and ROB.

Parameters:
N_WAY, 3, broadcast lanes per cycle
CDB_BITS, 6, physical register tag width; tag 0 is the reserved null tag
N_FU, 4, functional unit completion ports
QUEUE_DEPTH, 8, overflow queue entries (must be >= N_FU)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
fu_done_valid  in  N_FU  FU i has a completed result this cycle
fu_done_tag  in  N_FU x CDB_BITS  destination tag of FU i
fu_stall  out  N_FU  FU must hold its result; input not consumed
ex_rs_dest_idx  out  N_WAY x CDB_BITS  early wakeup tags, broadcast on the CDB next cycle
cdb_rs_reg_idx  out  N_WAY x CDB_BITS  CDB broadcast tags
cdb_valid  out  N_WAY  lane carries a real tag
queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied queue entries

Behaviour:
- Reset (sampled at posedge):
  - All outputs go to 0; queue empty; count 0.
  - Pending tags in the queue, ex stage and cdb stage are discarded and never broadcast.
  - Reset mid-operation behaves identically.
- Input acceptance at edge k:
  - fu_done_valid[i] is consumed only if fu_stall[i]=0.
  - A valid input carrying tag 0 is consumed and dropped: never queued, never broadcast.
- Selection at edge k, up to N_WAY tags:
  - First from the queue, head first, in FIFO order.
  - Then from the consumed inputs of this cycle, ascending FU index.
  - Selected tags load the ex stage, packed into lanes 0 upward.
  - Unused lanes hold tag 0.
- Queue push:
  - Consumed non-null inputs not selected are pushed in ascending FU index order, after any queue entries still remaining.
  - Push and pop in the same edge are allowed.
  - Count updates by pushes minus pops.
- Pipeline:
  - cdb stage loads the ex stage contents every edge, lane for lane.
  - cdb_valid[j] = (cdb_rs_reg_idx[j] != 0), registered.
  - Latency with empty queue: tag sampled at edge k appears on ex_rs_dest_idx after edge k and on cdb_rs_reg_idx after edge k+1, for exactly one cycle each.
- Backpressure:
  - fu_stall is registered.
  - All bits assert after an edge where QUEUE_DEPTH - count < N_FU, using the post-update count.
  - All bits deassert otherwise.
  - This guarantees a cycle's inputs always fit. Queue overflow is impossible, and no tag is lost or duplicated.
- Ordering: a tag never overtakes a tag queued before it. Within one cycle, lower FU index goes first.
- Throughput: the queue drains at up to N_WAY per cycle when no inputs arrive.

Test Plan:
1. Reset held 2 cycles, then idle -> all outputs, cdb_valid and queue_count are 0; fu_stall=0000.
2. FU0 done tag 33 at edge k, queue empty -> ex_rs_dest_idx={0,0,33} after k; cdb_rs_reg_idx[0]=33 and cdb_valid=001 after k+1; all lanes 0 after k+2.
3. FUs 0-3 done with tags 33,34,35,36 at edge k -> ex lanes 0..2 = 33,34,35 and queue_count=1 after k; with no new inputs, ex lane0=36 and count=0 after k+1; cdb lane0=36 after k+2.
4. Queue holds 40; FU1 done 41 and FU2 done with tag 0 at edge k -> ex lanes = 40,41,0; count=0; tag 0 never appears with cdb_valid=1.
5. All 4 FUs complete every cycle with unique tags -> count rises by 1 per edge; fu_stall=1111 after the edge where count reaches 5; inputs held while stalled are not consumed; queue drains by 3 per edge; stall clears once count <= 4; every tag is broadcast exactly once in acceptance order.
6. Count=3, ex and cdb stages full, reset asserted for one edge -> after that edge all lanes are 0, count=0, fu_stall=0000; the queued tags never appear on either bus.
